// File: rtl/ex_flags_wb_pkg.sv
// Shared definitions for the ex_flags_wb stage: EFLAGS bit positions, flag-mask
// index order, reserved-bit handling and reset value.
package ex_flags_wb_pkg;
  localparam int CF_BIT = 0;
  localparam int PF_BIT = 2;
  localparam int AF_BIT = 4;
  localparam int ZF_BIT = 6;
  localparam int SF_BIT = 7;
  localparam int DF_BIT = 10;
  localparam int OF_BIT = 11;

  // Index of each flag within the 7-bit write mask {OF,DF,SF,ZF,AF,PF,CF}
  localparam int MI_CF = 0;
  localparam int MI_PF = 1;
  localparam int MI_AF = 2;
  localparam int MI_ZF = 3;
  localparam int MI_SF = 4;
  localparam int MI_DF = 5;
  localparam int MI_OF = 6;
  localparam int FW    = 7;

  localparam logic [31:0] EFLAGS_DEFINED = 32'h0000_0CD5;
  localparam logic [31:0] EFLAGS_ONES    = 32'h0000_0002;
  localparam logic [31:0] EFLAGS_RESET   = 32'h0000_0002;
endpackage

// File: rtl/ex_flags_wb_flags_merge.sv
// flags_merge: overlays masked flag bits onto an EFLAGS word, forcing the
// reserved bits to their fixed values.
module flags_merge
  import ex_flags_wb_pkg::*;
(
  input  logic [31:0]   i_base,
  input  logic [31:0]   i_flags,
  input  logic [FW-1:0] i_we,
  output logic [31:0]   o_eflags
);
  logic [31:0] w_bm;

  always_comb begin
    w_bm         = '0;
    w_bm[CF_BIT] = i_we[MI_CF];
    w_bm[PF_BIT] = i_we[MI_PF];
    w_bm[AF_BIT] = i_we[MI_AF];
    w_bm[ZF_BIT] = i_we[MI_ZF];
    w_bm[SF_BIT] = i_we[MI_SF];
    w_bm[DF_BIT] = i_we[MI_DF];
    w_bm[OF_BIT] = i_we[MI_OF];
  end

  assign o_eflags = (((i_base & ~w_bm) | (i_flags & w_bm)) & EFLAGS_DEFINED) | EFLAGS_ONES;
endmodule

// File: rtl/ex_flags_wb.sv
// Execute-to-writeback buffer with architectural EFLAGS commit.
// FLAGS_BYPASS_EN: eflags forwards buffered entries' flags and flags_busy is 0.
module ex_flags_wb #(
  parameter int          DEPTH        = 2,
  parameter logic [31:0] EFLAGS_RESET = ex_flags_wb_pkg::EFLAGS_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_flags,
  input  logic [6:0]  ex_flag_we,
  input  logic [2:0]  ex_dest,
  input  logic        ex_reg_we,
  input  logic        flush,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_result,
  output logic [2:0]  wb_dest,
  output logic        wb_reg_we,
  output logic [31:0] eflags,
  output logic        flags_busy
);
  import ex_flags_wb_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_result [DEPTH];
  logic [31:0]   r_flags  [DEPTH];
  logic [FW-1:0] r_fwe    [DEPTH];
  logic [2:0]    r_dest   [DEPTH];
  logic          r_rwe    [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_eflags;

  logic w_empty, w_full, w_enq, w_deq;
  logic [31:0] w_commit;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_enq   = ex_valid & ~w_full;
  assign w_deq   = wb_ready & ~w_empty;

  flags_merge u_commit (
    .i_base  (r_eflags),
    .i_flags (r_flags[r_head]),
    .i_we    (r_fwe[r_head]),
    .o_eflags(w_commit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_eflags <= EFLAGS_RESET;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_result[r_tail] <= ex_result;
        r_flags[r_tail]  <= ex_flags;
        r_fwe[r_tail]    <= ex_flag_we;
        r_dest[r_tail]   <= ex_dest;
        r_rwe[r_tail]    <= ex_reg_we;
        r_tail           <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_head   <= r_head + 1'b1;
        r_eflags <= w_commit;
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  assign ex_ready  = ~w_full;
  assign wb_valid  = ~w_empty;
  assign wb_result = w_empty ? '0 : r_result[r_head];
  assign wb_dest   = w_empty ? '0 : r_dest[r_head];
  assign wb_reg_we = ~w_empty & r_rwe[r_head];

`ifdef FLAGS_BYPASS_EN
  // Chain position k holds the k-th oldest entry; empty positions merge nothing.
  logic [31:0] w_chain [DEPTH+1];
  assign w_chain[0] = r_eflags;

  for (genvar k = 0; k < DEPTH; k++) begin : g_fwd
    logic [AW-1:0] w_idx;
    logic [FW-1:0] w_we;
    assign w_idx = r_head + AW'(k);
    assign w_we  = (CW'(k) < r_count) ? r_fwe[w_idx] : '0;
    flags_merge u_fwd (
      .i_base  (w_chain[k]),
      .i_flags (r_flags[w_idx]),
      .i_we    (w_we),
      .o_eflags(w_chain[k+1])
    );
  end

  assign eflags     = w_chain[DEPTH];
  assign flags_busy = 1'b0;
`else
  logic w_busy;
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      if ((CW'(k) < r_count) && (|r_fwe[r_head + AW'(k)])) w_busy = 1'b1;
  end

  assign eflags     = r_eflags;
  assign flags_busy = w_busy;
`endif
endmodule

// File: tb/tb_ex_flags_wb.sv
// Directed table-driven bench for ex_flags_wb plus hand sequences for the
// full-while-dequeuing and mid-operation reset cases.
module tb_ex_flags_wb;
  logic        clk = 1'b0;
  logic        reset, ex_valid, ex_ready, ex_reg_we, flush, wb_valid, wb_ready, wb_reg_we, flags_busy;
  logic [31:0] ex_result, ex_flags, wb_result, eflags;
  logic [6:0]  ex_flag_we;
  logic [2:0]  ex_dest, wb_dest;

  int checks = 0;
  int errors = 0;

  ex_flags_wb dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_flags(ex_flags), .ex_flag_we(ex_flag_we),
    .ex_dest(ex_dest), .ex_reg_we(ex_reg_we), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_dest(wb_dest), .wb_reg_we(wb_reg_we), .eflags(eflags), .flags_busy(flags_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [31:0] res;
    logic [31:0] fl;
    logic [6:0]  fwe;
    logic [2:0]  dest;
    logic        rwe;
    logic        wbr;
    logic        flsh;
    logic        x_wbv;
    logic        x_rdy;
    logic [31:0] x_res;
    logic [2:0]  x_dest;
    logic        x_rwe;
    logic [31:0] x_ef_arch;
    logic [31:0] x_ef_fwd;
    logic        x_busy;
  } vec_t;

  vec_t tv[23];

  function automatic vec_t mk(logic ev, logic [31:0] res, logic [31:0] fl, logic [6:0] fwe,
                              logic [2:0] dest, logic rwe, logic wbr, logic flsh,
                              logic x_wbv, logic x_rdy, logic [31:0] x_res, logic [2:0] x_dest,
                              logic x_rwe, logic [31:0] x_ef_arch, logic [31:0] x_ef_fwd,
                              logic x_busy);
    vec_t v;
    v.ev = ev; v.res = res; v.fl = fl; v.fwe = fwe; v.dest = dest; v.rwe = rwe;
    v.wbr = wbr; v.flsh = flsh; v.x_wbv = x_wbv; v.x_rdy = x_rdy; v.x_res = x_res;
    v.x_dest = x_dest; v.x_rwe = x_rwe; v.x_ef_arch = x_ef_arch; v.x_ef_fwd = x_ef_fwd;
    v.x_busy = x_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_valid = v.ev; ex_result = v.res; ex_flags = v.fl; ex_flag_we = v.fwe;
    ex_dest = v.dest; ex_reg_we = v.rwe; wb_ready = v.wbr; flush = v.flsh;
  endtask

  task automatic idle();
    ex_valid = 0; ex_result = '0; ex_flags = '0; ex_flag_we = '0;
    ex_dest = '0; ex_reg_we = 0; wb_ready = 0; flush = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_wb_valid"},   32'(wb_valid),   32'd0);
    chk({tag, "_ex_ready"},   32'(ex_ready),   32'd1);
    chk({tag, "_flags_busy"}, 32'(flags_busy), 32'd0);
    chk({tag, "_eflags"},     eflags,          32'h2);
    chk({tag, "_wb_result"},  wb_result,       32'h0);
    chk({tag, "_wb_dest"},    32'(wb_dest),    32'h0);
    chk({tag, "_wb_reg_we"},  32'(wb_reg_we),  32'h0);
  endtask

  initial begin
    //            ev res           flags         fwe    d  rw wbr fl | wbv rdy res           d  rw ef_arch       ef_fwd        busy
    tv[0]  = mk(1, 32'h0,        32'h44,       7'h7F, 1, 1, 1, 0,   1, 1, 32'h0,        1, 1, 32'h2,   32'h46,  1);
    tv[1]  = mk(0, 32'h0,        32'h0,        7'h00, 0, 0, 1, 0,   0, 1, 32'h0,        0, 0, 32'h46,  32'h46,  0);
    tv[2]  = mk(1, 32'hAAAA0001, 32'h1,        7'h00, 2, 1, 0, 0,   1, 1, 32'hAAAA0001, 2, 1, 32'h46,  32'h46,  0);
    tv[3]  = mk(1, 32'hBBBB0002, 32'h0,        7'h00, 3, 0, 0, 0,   1, 0, 32'hAAAA0001, 2, 1, 32'h46,  32'h46,  0);
    tv[4]  = mk(1, 32'hCCCC0003, 32'h0,        7'h00, 4, 1, 0, 0,   1, 0, 32'hAAAA0001, 2, 1, 32'h46,  32'h46,  0);
    tv[5]  = mk(1, 32'hCCCC0003, 32'h0,        7'h00, 4, 1, 1, 0,   1, 1, 32'hBBBB0002, 3, 0, 32'h46,  32'h46,  0);
    tv[6]  = mk(1, 32'hCCCC0003, 32'h0,        7'h00, 4, 1, 1, 0,   1, 1, 32'hCCCC0003, 4, 1, 32'h46,  32'h46,  0);
    tv[7]  = mk(0, 32'h0,        32'h0,        7'h00, 0, 0, 1, 0,   0, 1, 32'h0,        0, 0, 32'h46,  32'h46,  0);
    tv[8]  = mk(1, 32'hD,        32'h400,      7'h20, 5, 0, 0, 0,   1, 1, 32'hD,        5, 0, 32'h46,  32'h446, 1);
    tv[9]  = mk(0, 32'h0,        32'h0,        7'h00, 0, 0, 1, 0,   0, 1, 32'h0,        0, 0, 32'h446, 32'h446, 0);
    tv[10] = mk(1, 32'hE,        32'h0,        7'h20, 6, 0, 1, 0,   1, 1, 32'hE,        6, 0, 32'h446, 32'h46,  1);
    tv[11] = mk(0, 32'h0,        32'h0,        7'h00, 0, 0, 1, 0,   0, 1, 32'h0,        0, 0, 32'h46,  32'h46,  0);
    tv[12] = mk(1, 32'h1234,     32'hFFFFFFFF, 7'h7F, 7, 0, 0, 0,   1, 1, 32'h1234,     7, 0, 32'h46,  32'hCD7, 1);
    tv[13] = mk(0, 32'h0,        32'h0,        7'h00, 0, 0, 1, 0,   0, 1, 32'h0,        0, 0, 32'hCD7, 32'hCD7, 0);
    tv[14] = mk(1, 32'hF1,       32'h0,        7'h01, 1, 1, 0, 0,   1, 1, 32'hF1,       1, 1, 32'hCD7, 32'hCD6, 1);
    tv[15] = mk(1, 32'hF2,       32'h0,        7'h40, 2, 0, 0, 0,   1, 0, 32'hF1,       1, 1, 32'hCD7, 32'h4D6, 1);
    tv[16] = mk(1, 32'hF3,       32'h0,        7'h7F, 3, 1, 1, 1,   0, 1, 32'h0,        0, 0, 32'hCD7, 32'hCD7, 0);
    tv[17] = mk(0, 32'h0,        32'h0,        7'h00, 0, 0, 0, 0,   0, 1, 32'h0,        0, 0, 32'hCD7, 32'hCD7, 0);
    tv[18] = mk(1, 32'h55,       32'h0,        7'h7F, 0, 1, 1, 0,   1, 1, 32'h55,       0, 1, 32'hCD7, 32'h2,   1);
    tv[19] = mk(0, 32'h0,        32'h0,        7'h00, 0, 0, 1, 0,   0, 1, 32'h0,        0, 0, 32'h2,   32'h2,   0);
    tv[20] = mk(1, 32'h66,       32'h1,        7'h01, 2, 0, 0, 0,   1, 1, 32'h66,       2, 0, 32'h2,   32'h3,   1);
    tv[21] = mk(0, 32'h0,        32'h0,        7'h00, 0, 0, 0, 0,   1, 1, 32'h66,       2, 0, 32'h2,   32'h3,   1);
    tv[22] = mk(0, 32'h0,        32'h0,        7'h00, 0, 0, 1, 0,   0, 1, 32'h0,        0, 0, 32'h3,   32'h3,   0);

    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk) reset = 0;
    @(posedge clk);
    #1 check_reset_state("idle");

    for (int i = 0; i < 23; i++) begin
      @(negedge clk) drive(tv[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wb_valid", i),  32'(wb_valid),  32'(tv[i].x_wbv));
      chk($sformatf("v%0d_ex_ready", i),  32'(ex_ready),  32'(tv[i].x_rdy));
      chk($sformatf("v%0d_wb_result", i), wb_result,      tv[i].x_res);
      chk($sformatf("v%0d_wb_dest", i),   32'(wb_dest),   32'(tv[i].x_dest));
      chk($sformatf("v%0d_wb_reg_we", i), 32'(wb_reg_we), 32'(tv[i].x_rwe));
`ifdef FLAGS_BYPASS_EN
      chk($sformatf("v%0d_eflags", i),     eflags,          tv[i].x_ef_fwd);
      chk($sformatf("v%0d_flags_busy", i), 32'(flags_busy), 32'd0);
`else
      chk($sformatf("v%0d_eflags", i),     eflags,          tv[i].x_ef_arch);
      chk($sformatf("v%0d_flags_busy", i), 32'(flags_busy), 32'(tv[i].x_busy));
`endif
    end

    // Full FIFO with writeback ready: ex_ready must not rise before the edge.
    @(negedge clk) begin
      idle(); ex_valid = 1; ex_result = 32'h71; ex_flag_we = 7'h01; ex_flags = 32'h0;
    end
    @(posedge clk);
    @(negedge clk) ex_result = 32'h72;
    @(posedge clk);
    @(negedge clk) begin ex_valid = 0; wb_ready = 1; end
    #1 chk("full_deq_ready_comb", 32'(ex_ready), 32'd0);
    chk("full_deq_head", wb_result, 32'h71);

    // Reset mid-operation outranks flush and enqueue.
    @(negedge clk) begin reset = 1; flush = 1; ex_valid = 1; end
    @(posedge clk);
    #1 check_reset_state("midreset");
    @(negedge clk) begin reset = 0; idle(); end
    @(posedge clk);
    #1 check_reset_state("postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_flags_wb.md
Name: ex_flags_wb

Overview:
- Execute-to-writeback stage directly downstream of the 32-bit ALU.
- Buffers each ALU result, its 32-bit flags word and a per-flag write mask in a 2-entry FIFO.
- Holds the architectural EFLAGS register and commits flags into it when an entry is accepted by writeback.
- Provides current EFLAGS to execute (for CMP/conditional consumers) and back-pressures execute when buffered.

Parameters:
- DEPTH, 2, buffer entries (power of two, min 2)
- EFLAGS_RESET, 32'h0000_0002, EFLAGS value at reset (bit1 reserved-one)

Ports:
- clk  in  1  stage clock
- reset  in  1  synchronous active-high reset
- ex_valid  in  1  execute presents an entry
- ex_ready  out  1  stage can accept (not full)
- ex_result  in  32  ALU output
- ex_flags  in  32  ALU flags word (CF b0, PF b2, AF b4, ZF b6, SF b7, DF b10, OF b11)
- ex_flag_we  in  7  write mask {OF,DF,SF,ZF,AF,PF,CF}
- ex_dest  in  3  destination register id
- ex_reg_we  in  1  entry writes a register
- flush  in  1  discard all buffered entries
- wb_valid  out  1  head entry available
- wb_ready  in  1  writeback accepts head
- wb_result  out  32  head result
- wb_dest  out  3  head destination id
- wb_reg_we  out  1  head register write enable
- eflags  out  32  architectural EFLAGS
- flags_busy  out  1  a buffered entry has a nonzero flag mask

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: FIFO empty, wb_valid=0, ex_ready=1, flags_busy=0, eflags=EFLAGS_RESET, wb_result/wb_dest/wb_reg_we=0.
- Enqueue: on ex_valid & ex_ready at a rising edge, the entry is written at the tail. ex_ready = !full and is purely a function of occupancy. When full and dequeuing in the same cycle, ex_ready remains 0 (no combinational ready path).
- Dequeue: on wb_valid & wb_ready at a rising edge, the head pops. In the same edge, for each mask bit i set, the corresponding eflags bit takes the head's flag bit. Unmasked bits hold.
- Latency: an entry enqueued at edge N is visible on wb_* after edge N (1 cycle). eflags is updated at the dequeue edge.
- Simultaneous enqueue and dequeue: occupancy is unchanged. Legal when full (dequeue only) and when empty (enqueue only; the new entry is not bypassed to the output).
- wb_* outputs are driven from the head slot, and are zero when empty.
- Wrap-around: head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are resolved by an occupancy counter of 0..DEPTH.
- flush: takes priority over enqueue and dequeue. It empties the FIFO at the edge and leaves eflags unchanged (no commit that cycle).
- reset mid-operation: takes priority over flush. All state returns to reset values.
- eflags bits 1 = 1, and reserved bits 3, 5, 8, 9, 12–31 are forced to 0 regardless of the mask.
- flags_busy = OR over valid entries of |flag_we.

Optional Feature:
- FLAGS_BYPASS_EN defined:
  - eflags presents a forwarded value: the architectural EFLAGS merged oldest-to-youngest with every valid buffered entry's masked flags.
  - flags_busy is tied 0.
- Undefined:
  - eflags is architectural only.
  - Execute must stall while flags_busy=1.

Decomposition:
- Shared package/header holds:
  - flag bit-position constants (CF_BIT=0, PF_BIT=2, AF_BIT=4, ZF_BIT=6, SF_BIT=7, DF_BIT=10, OF_BIT=11)
  - flag mask index order
  - EFLAGS reserved-bit mask
  - EFLAGS_RESET
- One sub-module, flags_merge: applies a 7-bit mask and new flags onto a 32-bit EFLAGS word. It is used for commit and, under FLAGS_BYPASS_EN, chained per entry for forwarding.

Test Plan:
- Reset then idle -> eflags=32'h2, wb_valid=0, ex_ready=1, flags_busy=0.
- Enqueue ADD result 0 with flags ZF|PF (32'h44) and mask 7'h7F, wb_ready=1 -> wb_valid next cycle with wb_result=0. After the dequeue edge, eflags=32'h46.
- Fill with wb_ready=0 -> ex_ready=0 after 2 entries, third ex_valid is not accepted. Then raise wb_ready with ex_valid held -> one pop per cycle and order preserved across pointer wrap (entries A,B,C out in order).
- Entry with mask 7'h20 (DF only), flags 32'h400 -> only bit10 set in eflags; a following CLD entry (mask 7'h20, flags 0) clears it.
- Two entries buffered, assert flush with ex_valid=1 -> FIFO empty next cycle, eflags unchanged, new entry not captured.
- With FLAGS_BYPASS_EN: buffered CMP entry setting CF (mask 7'h01, flags 32'h1), wb_ready=0 -> eflags shows bit0=1 immediately and flags_busy=0. Without the macro -> eflags bit0=0 and flags_busy=1 until dequeue.
